// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the multicycle MIPS core.
// Keeps the program counter and has at most one instruction-memory request
// outstanding. It latches the returned word and holds it until the
// downstream stage consumes it. On consume it computes the next PC:
// sequential, BEQ-taken, or J.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        mux_branch_jump,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_target_w;
    logic [31:0] jump_target_w;
    logic [31:0] next_pc_w;
    logic        consume_w;

    assign pc_plus4_w      = pc_q + 32'd4;
    // Shift by two: drop the top two offset bits and append two zero bits.
    assign branch_target_w = pc_plus4_w + {branch_offset[29:0], 2'b00};
    assign jump_target_w   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    assign consume_w       = (state_q == HOLD) && instr_valid_q && !stall;

    // Next-PC select: jump beats a taken branch, which beats sequential.
    always_comb begin
        next_pc_w = pc_plus4_w;
        if (!mux_branch_jump) begin
            next_pc_w = jump_target_w;
        end else if (branch && zero) begin
            next_pc_w = branch_target_w;
        end
    end

    // FSM next-state logic and request generation.
    // Reset overrides everything in the register block below.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_count_d = instr_count_q;
        imem_req      = 1'b0;
        unique case (state_q)
            FETCH: begin
                // Suppress the request during reset so an in-flight reset
                // never starts a new transaction.
                imem_req = !rst;
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                // A late or spurious ack in this state is ignored.
                if (consume_w) begin
                    pc_d          = next_pc_w;
                    instr_valid_d = 1'b0;
                    instr_count_d = instr_count_q + 32'd1;
                    state_d       = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State registers. Reset wins over a simultaneous ack or consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Expected fetch addresses go into a queue
// when each consume is driven. They are popped and compared when the DUT
// raises its next request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        mux_branch_jump;
    logic        zero;
    logic [31:0] branch_offset;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_count = 32'd0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .branch          (branch),
        .mux_branch_jump (mux_branch_jump),
        .zero            (zero),
        .branch_offset   (branch_offset),
        .instr           (instr),
        .opcode          (opcode),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, then check its address against the scoreboard.
    task automatic wait_req(output logic [31:0] a);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
            a = 32'd0;
        end else begin
            a = exp_q.pop_front();
        end
        check("imem_addr", imem_addr, a);
        check("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
    endtask

    // One complete transaction: request, wait states, ack, stall, consume.
    task automatic step(input logic [31:0] word, input int lat, input int stl,
                        input logic br, input logic mbj, input logic z,
                        input logic [31:0] off, input logic [31:0] nxt);
        logic [31:0] a;
        wait_req(a);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("addr_stable", imem_addr, a);
            check("req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("valid_set", {31'd0, instr_valid}, 32'd1);
        check("instr", instr, word);
        check("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
        check("pc", pc, a);
        check("pc_plus4", pc_plus4, a + 32'd4);
        check("req_in_hold", {31'd0, imem_req}, 32'd0);
        // Stall, with a stray ack that must be ignored.
        stall = 1'b1;
        for (int i = 0; i < stl; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_0000 + i;
            @(negedge clk);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, word);
            check("stall_pc", pc, a);
            check("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        imem_ack        = 1'b0;
        imem_rdata      = 32'd0;
        stall           = 1'b0;
        branch          = br;
        mux_branch_jump = mbj;
        zero            = z;
        branch_offset   = off;
        exp_count       = exp_count + 32'd1;
        exp_q.push_back(nxt);
        @(negedge clk);
        branch          = 1'b0;
        mux_branch_jump = 1'b1;
        zero            = 1'b0;
        branch_offset   = 32'd0;
        check("valid_clear", {31'd0, instr_valid}, 32'd0);
        check("instr_count", instr_count, exp_count);
        $display("txn pc=%h instr=%h next=%h count=%0d", a, word, nxt, exp_count);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_pc4"}, pc_plus4, 32'd4);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_opcode"}, {26'd0, opcode}, 32'd0);
        check({tag, "_count"}, instr_count, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst             = 1'b1;
        imem_ack        = 1'b0;
        imem_rdata      = 32'd0;
        stall           = 1'b0;
        branch          = 1'b0;
        mux_branch_jump = 1'b1;
        zero            = 1'b0;
        branch_offset   = 32'd0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("reset");
        end
        rst = 1'b0;
        exp_q.push_back(32'h0000_0000);

        // Sequential, zero-wait memory.
        step(32'h2008_0005, 0, 0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0004);
        step(32'h0109_5020, 0, 0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0008);
        // Wait states and stall.
        step(32'h8C00_0000, 3, 4, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_000C);
        step(32'h0000_0000, 1, 0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0010);
        // BEQ at 0x10, offset -2, taken and not taken.
        step(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_000C);
        step(32'h0000_0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0010);
        step(32'h1000_FFFE, 0, 1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0014);
        // Large branch to reach the upper address half.
        step(32'h1000_000A, 2, 0, 1'b1, 1'b1, 1'b1, 32'h2000_000A, 32'h8000_0040);
        // J at 0x8000_0040; branch and zero asserted but must not matter.
        step(32'h0800_0100, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h8000_0400);

        // Reset while the request at 0x8000_0400 is outstanding; ack during reset.
        wait_req(a);
        @(negedge clk);
        check("req_waiting", {31'd0, imem_req}, 32'd1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("req_forced_low", {31'd0, imem_req}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_reset_vals("midreset");
        end
        rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exp_count  = 32'd0;
        exp_q.push_back(32'h0000_0000);
        $display("txn mid-fetch reset at %h, restart at 00000000", a);

        // Branch back to 0xFFFF_FFFC, then sequential wrap to 0.
        step(32'h1000_FFFE, 2, 0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
        step(32'h0000_0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0000);

        // Reset coinciding with a consume: reset wins, count clears.
        wait_req(a);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("pre_rc_valid", {31'd0, instr_valid}, 32'd1);
        check("pre_rc_count", instr_count, exp_count);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_consume");
        rst = 1'b0;
        exp_q.push_back(32'h0000_0000);
        wait_req(a);
        $display("txn reset-with-consume, restart at %h", a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle MIPS core. Holds the program counter, issues one request at a time to instruction memory, latches the returned word and presents its opcode to the control decoder. When the instruction is consumed, it computes the next PC from the control unit's branch/jump selects: sequential, BEQ-taken, or J.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word, valid only with imem_ack.
- stall  in  1  downstream not ready; holds the current instruction.
- branch  in  1  current instruction is BEQ (from control decoder).
- mux_branch_jump  in  1  0 = current instruction is J; 1 = not a jump.
- zero  in  1  ALU zero flag for the current instruction.
- branch_offset  in  32  sign-extended immediate of the current instruction.
- instr  out  32  latched instruction word.
- opcode  out  6  instr[31:26]; feeds the control decoder.
- instr_valid  out  1  instr holds a fetched, unconsumed instruction.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc + 4.
- instr_count  out  32  count of consumed instructions.

## Operation
- FSM has two states: FETCH and HOLD.
- FETCH:
  - imem_req = 1 (forced 0 while rst is high).
  - imem_addr = pc, held stable until ack.
  - On imem_ack: instr <= imem_rdata, instr_valid <= 1, go to HOLD.
- HOLD:
  - imem_req = 0.
  - imem_ack in this state is ignored.
  - consume = instr_valid & ~stall.
  - On consume: pc <= next_pc, instr_valid <= 0, instr_count <= instr_count + 1, go to FETCH.
  - While stall = 1: instr, pc and instr_valid hold.
- next_pc priority:
  1. mux_branch_jump == 0: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. else branch & zero: pc_plus4 + (branch_offset << 2).
  3. else pc_plus4.
- Arithmetic is 32-bit modulo 2^32; pc + 4 and branch targets wrap silently.
- pc[1:0] is always 00; the low bits of branch_offset << 2 are 0 by construction.
- branch, zero, mux_branch_jump and branch_offset are sampled only in the consume cycle.
- instr_count wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values while rst = 1 and in the first cycle after release:
  - state = FETCH, pc = RESET_PC, pc_plus4 = RESET_PC + 4.
  - instr = 0, opcode = 0, instr_valid = 0, instr_count = 0.
  - imem_req = 0 while rst = 1.
- First request: imem_req rises in the first cycle with rst = 0.
- Latency: request at cycle n with ack at cycle n + k (k ≥ 0) gives instr_valid = 1 at cycle n + k + 1.
- Zero-wait memory: ack in the same cycle as req is legal. Peak throughput is one instruction per 2 cycles.
- Consume at cycle m gives imem_req = 1 with the new imem_addr at m + 1.
- Reset mid-operation: rst in any state returns to the reset values on the next edge. An outstanding request is abandoned, and an imem_ack arriving while rst = 1 is discarded.
- Simultaneous rst and imem_ack: rst wins.
- Simultaneous rst and consume: rst wins; instr_count does not increment.
- Only one request is outstanding at a time. No new request is issued until the previous instruction is consumed.

## Test plan
- Reset / first fetch: rst held 3 cycles then released, RESET_PC = 0.
  - imem_req = 0 during reset; imem_req = 1 with imem_addr = 0 in the first cycle after release; instr_valid = 0.
- Sequential, zero-wait: ack same cycle with words 0x20080005, 0x01095020; stall = 0.
  - imem_addr sequence 0x0, 0x4; opcode 0x08 then 0x00.
  - instr_valid pulses every other cycle; instr_count = 2.
- Wait states and stall: ack 3 cycles after req; stall held 4 cycles.
  - imem_addr stable for all 4 request cycles.
  - instr_valid = 1, instr and pc unchanged during the stall.
  - No imem_req until stall drops.
- BEQ at pc 0x10, branch = 1, branch_offset = 0xFFFFFFFE (-2):
  - zero = 1 → next imem_addr = 0x0C.
  - zero = 0 → next imem_addr = 0x14.
- J at pc 0x8000_0040, instr = 0x08000100, mux_branch_jump = 0 → next imem_addr = 0x8000_0400, regardless of branch and zero.
- Reset mid-fetch and wrap:
  - rst asserted while a request is outstanding, with ack arriving during reset → ack ignored; fetch restarts at RESET_PC.
  - pc = 0xFFFF_FFFC sequential → next imem_addr = 0x0000_0000.
